// File: rtl/risc_toy_fetch.sv
// Instruction-fetch unit for the RISC_TOY pipeline: fetch PC, synchronous I-memory port,
// DEPTH-entry prefetch queue with a valid/ready decode handshake and zero-bubble redirect.
module risc_toy_fetch #(
    parameter int              AW         = 30,
    parameter int              DEPTH      = 4,
    parameter logic [AW-1:0]   RESET_ADDR = '0
) (
    input  logic          CLK,
    input  logic          RST,
    output logic          IREQ,
    output logic [AW-1:0] IADDR,
    input  logic [31:0]   INSTR,
    input  logic          REDIRECT,
    input  logic [AW-1:0] REDIRECT_ADDR,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [31:0]   OUT_INSTR,
    output logic [AW-1:0] OUT_ADDR,
    output logic          OUT_CTRL
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;
    localparam logic [OW-1:0] DEPTH_LIM = OW'(DEPTH);

    logic [AW-1:0] fpc;
    logic          inf;
    logic [AW-1:0] inf_addr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;

    logic [31:0]   q_instr [DEPTH];
    logic [AW-1:0] q_addr  [DEPTH];
    logic          q_ctrl  [DEPTH];

    logic          pop;
    logic          push;
    logic          issue;
    logic [OW-1:0] occupancy;
    logic          instr_ctrl;

    // Occupancy counts the in-flight fetch as a reserved slot, so a full queue can never be pushed.
    always_comb begin
        pop        = (cnt != '0) & OUT_READY;
        push       = inf & ~REDIRECT;
        occupancy  = {1'b0, cnt} + OW'(inf) - OW'(pop);
        issue      = ~RST & (REDIRECT | (occupancy < DEPTH_LIM));
        instr_ctrl = INSTR[31:27] inside {5'b01111, 5'b10000, 5'b10001, 5'b10010};
    end

    assign IREQ      = issue;
    assign IADDR     = REDIRECT ? REDIRECT_ADDR : fpc;
    assign OUT_VALID = (cnt != '0);
    assign OUT_INSTR = q_instr[rd_ptr];
    assign OUT_ADDR  = q_addr[rd_ptr];
    assign OUT_CTRL  = q_ctrl[rd_ptr];

    always_ff @(posedge CLK) begin
        if (RST) begin
            fpc      <= RESET_ADDR;
            inf      <= 1'b0;
            inf_addr <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_addr[i]  <= '0;
                q_ctrl[i]  <= 1'b0;
            end
        end else begin
            inf <= issue;
            if (issue) begin
                inf_addr <= IADDR;
                fpc      <= IADDR + 1'b1;
            end
            if (push) begin
                q_instr[wr_ptr] <= INSTR;
                q_addr[wr_ptr]  <= inf_addr;
                q_ctrl[wr_ptr]  <= instr_ctrl;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            // A redirect never pushes, so wr_ptr is stable and the flush simply catches rd up to it.
            if (REDIRECT) begin
                cnt    <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                cnt <= cnt + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_risc_toy_fetch.sv
// Self-checking bench for risc_toy_fetch: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based reference model.
module tb_risc_toy_fetch;

    localparam int            AW         = 30;
    localparam int            DEPTH      = 4;
    localparam logic [AW-1:0] RESET_ADDR = '0;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          IREQ;
    logic [AW-1:0] IADDR;
    logic [31:0]   INSTR = '0;
    logic          REDIRECT = 1'b0;
    logic [AW-1:0] REDIRECT_ADDR = '0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic [31:0]   OUT_INSTR;
    logic [AW-1:0] OUT_ADDR;
    logic          OUT_CTRL;

    risc_toy_fetch #(.AW(AW), .DEPTH(DEPTH), .RESET_ADDR(RESET_ADDR)) dut (
        .CLK(CLK), .RST(RST), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
        .REDIRECT(REDIRECT), .REDIRECT_ADDR(REDIRECT_ADDR),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_INSTR(OUT_INSTR),
        .OUT_ADDR(OUT_ADDR), .OUT_CTRL(OUT_CTRL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0]   instr;
        logic [AW-1:0] addr;
    } entry_t;

    typedef struct {
        bit            rst;
        bit            ready;
        bit            redir;
        logic [AW-1:0] raddr;
        bit            e_ireq;
        logic [AW-1:0] e_iaddr;
        bit            e_valid;
        logic [AW-1:0] e_addr;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    entry_t        mq[$];
    bit            m_ok       = 1'b0;
    bit            m_prev_rst = 1'b0;
    bit            m_inf      = 1'b0;
    logic [AW-1:0] m_inf_addr = '0;
    logic [AW-1:0] m_fpc      = '0;

    bit            mem_req  = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    bit            alt_mode = 1'b0;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        if (alt_mode && a == '1) return 32'h7800_0000;
        if (alt_mode && a == '0) return 32'h9000_0000;
        if (alt_mode && a == 1)  return 32'h2000_0000;
        return {a[4:0], a[26:0] ^ 27'h5A5_A5A5};
    endfunction

    function automatic bit is_ctrl(input logic [31:0] w);
        logic [4:0] op;
        op = w[31:27];
        return (op == 5'd15) || (op == 5'd16) || (op == 5'd17) || (op == 5'd18);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle's inputs just after the falling edge; memory answers last cycle's request.
    task automatic applyStimulus(input bit rst, input bit redir, input logic [AW-1:0] raddr,
                                 input bit ready);
        RST           = rst;
        REDIRECT      = redir;
        REDIRECT_ADDR = raddr;
        OUT_READY     = ready;
        INSTR         = mem_req ? mem_word(mem_addr) : $urandom;
        #1;
    endtask

    task automatic checkOutput();
        bit            e_valid;
        bit            pop;
        bit            e_ireq;
        logic [AW-1:0] e_iaddr;
        if (!m_ok) return;
        e_valid = (mq.size() != 0);
        pop     = e_valid && OUT_READY;
        e_ireq  = !RST && (REDIRECT || (mq.size() + int'(m_inf) - int'(pop) < DEPTH));
        e_iaddr = REDIRECT ? REDIRECT_ADDR : m_fpc;
        check("ireq", 64'(IREQ), 64'(e_ireq));
        check("iaddr", 64'(IADDR), 64'(e_iaddr));
        check("out_valid", 64'(OUT_VALID), 64'(e_valid));
        if (e_valid) begin
            check("out_instr", 64'(OUT_INSTR), 64'(mq[0].instr));
            check("out_addr", 64'(OUT_ADDR), 64'(mq[0].addr));
            check("out_ctrl", 64'(OUT_CTRL), 64'(is_ctrl(mq[0].instr)));
        end
        if (m_prev_rst) begin
            check("rst_instr", 64'(OUT_INSTR), 64'd0);
            check("rst_addr", 64'(OUT_ADDR), 64'd0);
            check("rst_ctrl", 64'(OUT_CTRL), 64'd0);
        end
    endtask

    // Clock edge: memory latches the request, reference model applies the cycle's rules.
    task automatic advance();
        bit            pop;
        bit            issue;
        logic [AW-1:0] ia;
        mem_req  = IREQ;
        mem_addr = IADDR;
        @(posedge CLK);
        if (RST) begin
            mq.delete();
            m_inf      = 1'b0;
            m_fpc      = RESET_ADDR;
            m_ok       = 1'b1;
            m_prev_rst = 1'b1;
        end else if (m_ok) begin
            pop   = (mq.size() != 0) && OUT_READY;
            issue = REDIRECT || (mq.size() + int'(m_inf) - int'(pop) < DEPTH);
            ia    = REDIRECT ? REDIRECT_ADDR : m_fpc;
            if (pop) void'(mq.pop_front());
            if (m_inf && !REDIRECT) mq.push_back('{instr: INSTR, addr: m_inf_addr});
            if (REDIRECT) mq.delete();
            m_inf = issue;
            if (issue) begin
                m_inf_addr = ia;
                m_fpc      = ia + 1'b1;
            end
            m_prev_rst = 1'b0;
        end
        @(negedge CLK);
    endtask

    task automatic cycle(input bit rst, input bit redir, input logic [AW-1:0] raddr, input bit ready);
        applyStimulus(rst, redir, raddr, ready);
        checkOutput();
        advance();
    endtask

    function automatic vec_t mk(input bit rst, input bit ready, input bit redir,
                                input logic [AW-1:0] raddr, input bit e_ireq,
                                input logic [AW-1:0] e_iaddr, input bit e_valid,
                                input logic [AW-1:0] e_addr);
        vec_t v;
        v.rst = rst; v.ready = ready; v.redir = redir; v.raddr = raddr;
        v.e_ireq = e_ireq; v.e_iaddr = e_iaddr; v.e_valid = e_valid; v.e_addr = e_addr;
        return v;
    endfunction

    initial begin
        vec_t vecs[$];

        // Backpressure from cycle 0, drain, then a redirect coinciding with the pop of addr 5.
        vecs.push_back(mk(1, 0, 0, 0,     0, 0,     0, 0));
        vecs.push_back(mk(1, 0, 0, 0,     0, 0,     0, 0));
        vecs.push_back(mk(0, 0, 0, 0,     1, 0,     0, 0));
        vecs.push_back(mk(0, 0, 0, 0,     1, 1,     0, 0));
        vecs.push_back(mk(0, 0, 0, 0,     1, 2,     1, 0));
        vecs.push_back(mk(0, 0, 0, 0,     1, 3,     1, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0, 4,     1, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0, 4,     1, 0));
        vecs.push_back(mk(0, 1, 0, 0,     1, 4,     1, 0));
        vecs.push_back(mk(0, 1, 0, 0,     1, 5,     1, 1));
        vecs.push_back(mk(0, 1, 0, 0,     1, 6,     1, 2));
        vecs.push_back(mk(0, 1, 0, 0,     1, 7,     1, 3));
        vecs.push_back(mk(0, 1, 0, 0,     1, 8,     1, 4));
        vecs.push_back(mk(0, 1, 1, 'h100, 1, 'h100, 1, 5));
        vecs.push_back(mk(0, 1, 0, 0,     1, 'h101, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,     1, 'h102, 1, 'h100));
        vecs.push_back(mk(0, 1, 0, 0,     1, 'h103, 1, 'h101));
        vecs.push_back(mk(0, 1, 0, 0,     1, 'h104, 1, 'h102));

        @(negedge CLK);
        $display("[TB] directed vector table");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].redir, vecs[i].raddr, vecs[i].ready);
            checkOutput();
            if (i > 0) begin
                check($sformatf("vec%0d_ireq", i), 64'(IREQ), 64'(vecs[i].e_ireq));
                check($sformatf("vec%0d_iaddr", i), 64'(IADDR), 64'(vecs[i].e_iaddr));
                check($sformatf("vec%0d_valid", i), 64'(OUT_VALID), 64'(vecs[i].e_valid));
                if (vecs[i].e_valid)
                    check($sformatf("vec%0d_addr", i), 64'(OUT_ADDR), 64'(vecs[i].e_addr));
            end
            advance();
        end

        $display("[TB] redirect with two queued entries and a fetch in flight");
        cycle(1, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        applyStimulus(0, 1, 'h100, 0);
        checkOutput();
        check("redir_iaddr", 64'(IADDR), 64'h100);
        check("redir_ireq", 64'(IREQ), 64'd1);
        advance();
        applyStimulus(0, 0, 0, 1);
        checkOutput();
        check("redir_bubble", 64'(OUT_VALID), 64'd0);
        advance();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 1);
            checkOutput();
            check("redir_tgt_valid", 64'(OUT_VALID), 64'd1);
            check("redir_tgt_addr", 64'(OUT_ADDR), 64'('h100 + i));
            advance();
        end

        $display("[TB] fetch PC wrap and control pre-decode");
        alt_mode = 1'b1;
        applyStimulus(0, 1, '1, 1);
        checkOutput();
        check("wrap_iaddr", 64'(IADDR), 64'(AW'('1)));
        advance();
        applyStimulus(0, 0, 0, 1);
        checkOutput();
        check("wrap_next_iaddr", 64'(IADDR), 64'd0);
        advance();
        applyStimulus(0, 0, 0, 1);
        checkOutput();
        check("wrap_addr_top", 64'(OUT_ADDR), 64'(AW'('1)));
        check("wrap_ctrl_br", 64'(OUT_CTRL), 64'd1);
        advance();
        applyStimulus(0, 0, 0, 1);
        checkOutput();
        check("wrap_addr_zero", 64'(OUT_ADDR), 64'd0);
        check("wrap_ctrl_jl", 64'(OUT_CTRL), 64'd1);
        advance();
        applyStimulus(0, 0, 0, 1);
        checkOutput();
        check("wrap_addr_one", 64'(OUT_ADDR), 64'd1);
        check("wrap_ctrl_other", 64'(OUT_CTRL), 64'd0);
        advance();
        alt_mode = 1'b0;

        $display("[TB] reset mid-stream together with redirect");
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
        applyStimulus(1, 1, 'h55, 1);
        checkOutput();
        check("rst_redir_ireq", 64'(IREQ), 64'd0);
        advance();
        applyStimulus(0, 0, 0, 1);
        checkOutput();
        check("post_rst_ireq", 64'(IREQ), 64'd1);
        check("post_rst_iaddr", 64'(IADDR), 64'(RESET_ADDR));
        check("post_rst_valid0", 64'(OUT_VALID), 64'd0);
        advance();
        applyStimulus(0, 0, 0, 1);
        checkOutput();
        check("post_rst_valid1", 64'(OUT_VALID), 64'd0);
        advance();
        applyStimulus(0, 0, 0, 1);
        checkOutput();
        check("post_rst_first", 64'(OUT_ADDR), 64'(RESET_ADDR));
        advance();

        $display("[TB] randomized traffic against reference model");
        for (int i = 0; i < 3000; i++) begin
            bit            rst;
            bit            redir;
            bit            ready;
            logic [AW-1:0] raddr;
            rst   = ($urandom_range(0, 199) == 0);
            redir = ($urandom_range(0, 15) == 0);
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) raddr = AW'('1) - AW'($urandom_range(0, 3));
            else                           raddr = AW'($urandom);
            cycle(rst, redir, raddr, ready);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
